// File: rtl/octal_rr_arbiter_if.sv
// Request/grant bundle between eight requesting units and the arbiter.
//   req          requester -> arbiter, bit i = requester i
//   grant        one-hot grant, zero when idle
//   grant_idx    binary index of the set grant bit, 0 when idle
//   grant_valid  high while grant is non-zero
//   preempt      one-cycle pulse after a forced revoke
interface octal_rr_arbiter_if;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       preempt;

  modport master (output req, input grant, grant_idx, grant_valid, preempt);
  modport slave  (input req, output grant, grant_idx, grant_valid, preempt);
endinterface

// File: rtl/octal_rr_arbiter.sv
// Eight-way round-robin arbiter with hold-time limit.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  octal_rr_arbiter_if.slave: req in; grant, grant_idx, grant_valid,
//        preempt out. All outputs come straight from registers.
// A winner keeps the slot while its request stays high. After MAX_HOLD
// grant cycles it is revoked if anyone else is waiting (MAX_HOLD=0 disables
// the limit). Every release/revoke is followed by one dead idle cycle.
module octal_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic clk,
  input  logic rst,
  octal_rr_arbiter_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  state_t           state, state_nxt;
  logic [2:0]       ptr, ptr_nxt;
  logic [2:0]       idx_q, idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pre_q, pre_nxt;
  logic [2:0]       winner;
  logic [7:0]       own_vec;
  logic             release_c, revoke_c;

  // First set request scanning ptr, ptr+1, .. ptr+7; iterate from the far
  // end so the nearest hit to ptr is the one left standing.
  always_comb begin
    winner = ptr;
    for (int k = 7; k >= 0; k--)
      if (bus.req[ptr + 3'(k)]) winner = ptr + 3'(k);
  end

  assign own_vec   = 8'b1 << idx_q;
  assign release_c = ~bus.req[idx_q];
  assign revoke_c  = (MAX_HOLD != 0) && (cnt == HOLD_LAST) && (|(bus.req & ~own_vec));

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      idx_q <= '0;
      cnt   <= '0;
      pre_q <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      idx_q <= idx_nxt;
      cnt   <= cnt_nxt;
      pre_q <= pre_nxt;
    end
  end

  // next-state
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = idx_q;
    cnt_nxt   = cnt;
    pre_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          state_nxt = GRANT;
          idx_nxt   = winner;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (release_c || revoke_c) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          ptr_nxt   = idx_q + 3'd1;
          cnt_nxt   = '0;
          // an owner that let go on its own is not a preemption
          pre_nxt   = ~release_c;
        end else if (cnt != HOLD_LAST) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // outputs (decoded from registers only)
  always_comb begin
    bus.grant       = (state == GRANT) ? own_vec : 8'h00;
    bus.grant_idx   = idx_q;
    bus.grant_valid = (state == GRANT);
    bus.preempt     = pre_q;
  end

endmodule

// File: tb/tb_octal_rr_arbiter.sv
module tb_octal_rr_arbiter;

  typedef struct {
    int         cyc;
    logic       v;
    logic [2:0] idx;
    logic       pre;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  exp_t q[$];

  octal_rr_arbiter_if ifc();

  octal_rr_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Apply req/rst for the coming edge and queue what the outputs must be
  // right after that edge.
  task automatic drive(input logic [7:0] r, input logic rs,
                       input logic v, input logic [2:0] idx, input logic pre);
    exp_t e;
    @(posedge clk);
    #1;
    ifc.req = r;
    rst     = rs;
    e.cyc = cyc + 1; e.v = v; e.idx = idx; e.pre = pre;
    q.push_back(e);
  endtask

  // scoreboard monitor + per-cycle invariant
  always @(negedge clk) begin
    if (cyc >= 2) begin
      logic [2:0] enc;
      logic       ok;
      enc = 3'd0;
      for (int i = 0; i < 8; i++) if (ifc.grant[i]) enc = 3'(i);
      ok = ($countones(ifc.grant) <= 1) && (ifc.grant_valid == (|ifc.grant)) &&
           (ifc.grant_idx == enc);
      total++;
      if (ok) passed++;
      else $display("FAIL invariant cyc=%0d grant=%h idx=%0d valid=%b", cyc,
                    ifc.grant, ifc.grant_idx, ifc.grant_valid);
    end
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [7:0] eg;
      e = q.pop_front();
      eg = e.v ? (8'b1 << e.idx) : 8'h00;
      total++;
      if (e.cyc == cyc && ifc.grant === eg && ifc.grant_idx === (e.v ? e.idx : 3'd0) &&
          ifc.grant_valid === e.v && ifc.preempt === e.pre)
        passed++;
      else
        $display("FAIL out cyc=%0d got grant=%h idx=%0d v=%b pre=%b want grant=%h idx=%0d v=%b pre=%b (due cyc %0d)",
                 cyc, ifc.grant, ifc.grant_idx, ifc.grant_valid, ifc.preempt,
                 eg, e.v ? e.idx : 3'd0, e.v, e.pre, e.cyc);
    end
  end

  initial begin
    ifc.req = 8'hFF;
    // 1 reset with all requests high
    drive(8'hFF, 1'b1, 0, 0, 0);
    drive(8'h00, 1'b1, 0, 0, 0);
    drive(8'h00, 1'b0, 0, 0, 0);
    // 2 single request, then ptr=6 shows as winner 6 over 0
    drive(8'h20, 1'b0, 1, 5, 0);
    drive(8'h00, 1'b0, 0, 0, 0);
    drive(8'h41, 1'b0, 1, 6, 0);
    drive(8'h00, 1'b0, 0, 0, 0);
    // 3 rotation 0..7 then wrap to 0
    drive(8'h00, 1'b1, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      drive(8'hFF, 1'b0, 1, 3'(i % 8), 0);
      drive(8'hFF & ~(8'b1 << (i % 8)), 1'b0, 0, 0, 0);
    end
    // 4 forced rotation with MAX_HOLD=4
    drive(8'h00, 1'b1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(8'h03, 1'b0, 1, 0, 0);
    drive(8'h03, 1'b0, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive(8'h03, 1'b0, 1, 1, 0);
    drive(8'h03, 1'b0, 0, 0, 1);
    drive(8'h03, 1'b0, 1, 0, 0);
    drive(8'h00, 1'b0, 0, 0, 0);
    // 5 sole requester keeps the slot (ptr=1 here)
    for (int i = 0; i < 50; i++) drive(8'h80, 1'b0, 1, 7, 0);
    drive(8'h00, 1'b0, 0, 0, 0);
    // 6 move ptr to 3, grant 3, reset mid-grant, then ptr 0 picks 2
    drive(8'h04, 1'b0, 1, 2, 0);
    drive(8'h00, 1'b0, 0, 0, 0);
    drive(8'h08, 1'b0, 1, 3, 0);
    drive(8'h0C, 1'b0, 1, 3, 0);
    drive(8'h0C, 1'b1, 0, 0, 0);
    drive(8'h0C, 1'b0, 1, 2, 0);
    drive(8'h00, 1'b0, 0, 0, 0);
    drive(8'h00, 1'b0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain left=%0d want 0", q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
